line_draw_arbiter: RTL

LINE_DRAW_ARBITER -- requirements
Module: line_draw_arbiter

---
 rtl/line_draw_arbiter.sv | 93 +++++++++
 1 files changed

// File: rtl/line_draw_arbiter.sv
// line_draw_arbiter: round-robin arbiter sharing one line drawer among NREQ requesters
module line_draw_arbiter #(
  parameter int NREQ = 3,
  parameter int CW = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] req_x0,
  input  logic [NREQ*CW-1:0] req_y0,
  input  logic [NREQ*CW-1:0] req_x1,
  input  logic [NREQ*CW-1:0] req_y1,
  input  logic [NREQ-1:0]    req_color,
  input  logic               done,
  output logic [CW-1:0]      x0,
  output logic [CW-1:0]      y0,
  output logic [CW-1:0]      x1,
  output logic [CW-1:0]      y1,
  output logic               color,
  output logic               start,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    ack,
  output logic               busy
);
  localparam int LW = NREQ > 1 ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, LAUNCH, DRAW} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic color_q, color_d;
  logic [NREQ-1:0] grant_q, grant_d, ack_q, ack_d;
  logic [LW-1:0] last_q, last_d, win, idx;
  logic launch, finish;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == IDLE && |req) ? LAUNCH :
              (state_q == LAUNCH) ? DRAW :
              (state_q == DRAW && done) ? IDLE : state_q;
  end
  // scan from last+1 upward with wrap; first requester found wins
  always_comb begin
    win = last_q;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = LW'((int'(last_q) + k) % NREQ);
      if (req[idx]) win = idx;
    end
  end
  always_comb begin
    launch  = state_q == IDLE && |req;
    finish  = state_q == DRAW && done;
    x0_d    = launch ? req_x0[win*CW +: CW] : x0_q;
    y0_d    = launch ? req_y0[win*CW +: CW] : y0_q;
    x1_d    = launch ? req_x1[win*CW +: CW] : x1_q;
    y1_d    = launch ? req_y1[win*CW +: CW] : y1_q;
    color_d = launch ? req_color[win] : color_q;
    grant_d = launch ? NREQ'(1) << win : finish ? '0 : grant_q;
    last_d  = launch ? win : last_q;
    ack_d   = finish ? NREQ'(1) << last_q : '0;
    start   = state_q == LAUNCH;
    busy    = state_q != IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= 1'b0;
      grant_q <= '0;
      ack_q   <= '0;
      last_q  <= LW'(NREQ - 1);
    end else begin
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      color_q <= color_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      last_q  <= last_d;
    end
  end
  assign x0    = x0_q;
  assign y0    = y0_q;
  assign x1    = x1_q;
  assign y1    = y1_q;
  assign color = color_q;
  assign grant = grant_q;
  assign ack   = ack_q;
endmodule
